dbus_arb: RTL and testbench
===========================

DBUS_ARB -- requirements
Module: dbus_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, master/slave address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; strobe width DATA_WIDTH/8.
REQ-003 SHALL have parameter BURST, default 8, range 1..255: max consecutive grants to one master under contention.
REQ-004 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have, per master x in {0,1}, ports mx_req in 1, mx_wr in 1 (1=write, 0=read), mx_addr in ADDR_WIDTH, mx_wdata in DATA_WIDTH, mx_wstrb in DATA_WIDTH/8.
REQ-007 SHALL have, per master, ports mx_gnt out 1 (transfer accepted this cycle), mx_rvalid out 1, mx_rdata out DATA_WIDTH.
REQ-008 SHALL have slave ports dmem_wr, dmem_waddr, dmem_wdata, dmem_wstrb, dmem_rd, dmem_raddr (out) and dmem_rdata (in, valid one cycle after dmem_rd).
REQ-009 SHALL have port m0_stall out 1 = m0_req & ~m0_gnt; it drives the CPU stall input. Master 0 is the CPU; master 1 is the UART loader.

Function
REQ-010 SHALL forward at most one transfer per cycle; mx_gnt SHALL be combinational from the mx_req inputs and the registered state.
REQ-011 SHALL drive the slave ports combinationally from the granted master; dmem_wr = gnt & wr and dmem_rd = gnt & ~wr; with no grant, all slave outputs SHALL be 0.
REQ-012 SHALL have FSM states IDLE, OWN0, OWN1, holding the owner of the previous cycle's grant; no grant -> IDLE.
REQ-013 SHALL grant a sole requester immediately in any state, with zero added latency.
REQ-014 SHALL, on contention, grant the current owner while its consecutive count < BURST, else grant the other master.
REQ-015 SHALL, on contention from IDLE, grant the master not granted most recently (register last_gnt).
REQ-016 SHALL keep a consecutive-grant counter, 8 bits and saturating: it increments on a grant to the owner, loads 1 on an owner change, and clears on an IDLE cycle.
REQ-017 SHALL register the read owner on a granted read; the following cycle it SHALL assert that master's mx_rvalid and pass dmem_rdata to its mx_rdata.
REQ-018 SHALL drive the non-owner's mx_rdata to 0 on a read return.
REQ-019 SHALL hold mx_rvalid low in cycles without a returning read; back-to-back reads from alternating masters SHALL each return to the correct master.
REQ-020 SHALL, with BURST=1, strictly alternate grants under continuous contention.

Reset
REQ-021 SHALL, while rst=1, force FSM=IDLE, last_gnt=1, counter=0, read owner cleared, and all gnt/rvalid/rdata/slave outputs to 0.
REQ-022 SHALL drop a read in flight when rst asserts; no mx_rvalid for it SHALL follow reset release.
REQ-023 SHALL, on simultaneous requests in the first cycle after reset release, grant master 0.

Configuration
REQ-024 SHALL, with DBUS_ARB_LOCK_EN defined, add inputs m0_lock and m1_lock (1 bit each).
REQ-025 SHALL, with DBUS_ARB_LOCK_EN, let an owner with lock=1 and req=1 keep the grant regardless of BURST.
REQ-026 SHALL, with DBUS_ARB_LOCK_EN, ignore lock from the non-owner.
REQ-027 SHALL, without DBUS_ARB_LOCK_EN, omit the lock ports, and arbitration SHALL follow REQ-013..REQ-016 only.

Structure
REQ-028 SHALL place the FSM state encoding, the master-index encoding and the BURST default in shared package dbus_arb_pkg.
REQ-029 SHALL implement the grant decision (req, state, count, last_gnt, lock -> gnt) in sub-module dbus_arb_rr; the top holds registers, muxes and the read-return path.

Verification
REQ-030 SHALL test: m0 reads 0x0100_0010 alone -> m0_gnt same cycle, dmem_raddr=0x0100_0010; next cycle m0_rvalid=1, m0_rdata=dmem_rdata.
REQ-031 SHALL test: BURST=8, both request continuously from IDLE after reset -> m0 granted 8 cycles, then m1 8 cycles, repeating; m0_stall=1 in exactly m1's cycles.
REQ-032 SHALL test: m1 writes 0xDEADBEEF strb 0xF to 0x0000_0040 while m0 is idle -> dmem_wr=1, dmem_wdata=0xDEADBEEF, dmem_rd=0, m1_rvalid never set.
REQ-033 SHALL test: alternating reads m0@0x0200_0000 and m1@0x0300_0004 with BURST=1 -> rvalid alternates m0,m1 one cycle after each grant, with correct data routing.
REQ-034 SHALL test: rst asserted the cycle after a granted read -> no rvalid after release; first contention then grants m0.
REQ-035 SHALL test, with DBUS_ARB_LOCK_EN: m1 owner with m1_lock=1 and m0 requesting -> m1 keeps the grant past 8 cycles; m0 granted the cycle after m1_lock falls with count >= BURST.

Source files
------------

// File: rtl/dbus_arb_pkg.sv
// dbus_arb_pkg -- shared definitions for the two-master data-bus arbiter.
//   arb_state_t   : arbiter FSM encoding (who owned the previous cycle's grant)
//   MST_0 / MST_1 : master index encoding (0 = CPU, 1 = UART loader)
//   BURST_DEFAULT : default cap on consecutive grants to one master under contention
//   cnt_sat_inc   : saturating increment for the 8-bit consecutive-grant counter
package dbus_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } arb_state_t;

   localparam logic MST_0 = 1'b0;
   localparam logic MST_1 = 1'b1;

   localparam int BURST_DEFAULT = 8;

   function automatic logic [7:0] cnt_sat_inc(input logic [7:0] c);
      return (c == 8'hFF) ? c : c + 8'd1;
   endfunction

endpackage

// File: rtl/dbus_arb_if.sv
// dbus_arb_if -- bundle of the two master request ports, their grant/read-return
// signals, the CPU stall output and the single data-memory port.
//   slave  modport : arbiter side (takes requests, drives grants and dmem_*)
//   master modport : requester/memory side (drives requests and dmem_rdata)
// Build option DBUS_ARB_LOCK_EN adds m0_lock / m1_lock.
interface dbus_arb_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic                  m0_req;
   logic                  m0_wr;
   logic [ADDR_WIDTH-1:0] m0_addr;
   logic [DATA_WIDTH-1:0] m0_wdata;
   logic [STRB_WIDTH-1:0] m0_wstrb;
   logic                  m0_gnt;
   logic                  m0_rvalid;
   logic [DATA_WIDTH-1:0] m0_rdata;
   logic                  m0_stall;

   logic                  m1_req;
   logic                  m1_wr;
   logic [ADDR_WIDTH-1:0] m1_addr;
   logic [DATA_WIDTH-1:0] m1_wdata;
   logic [STRB_WIDTH-1:0] m1_wstrb;
   logic                  m1_gnt;
   logic                  m1_rvalid;
   logic [DATA_WIDTH-1:0] m1_rdata;

`ifdef DBUS_ARB_LOCK_EN
   logic                  m0_lock;
   logic                  m1_lock;
`endif

   logic                  dmem_wr;
   logic [ADDR_WIDTH-1:0] dmem_waddr;
   logic [DATA_WIDTH-1:0] dmem_wdata;
   logic [STRB_WIDTH-1:0] dmem_wstrb;
   logic                  dmem_rd;
   logic [ADDR_WIDTH-1:0] dmem_raddr;
   logic [DATA_WIDTH-1:0] dmem_rdata;

   modport slave (
`ifdef DBUS_ARB_LOCK_EN
      input  m0_lock, m1_lock,
`endif
      input  m0_req, m0_wr, m0_addr, m0_wdata, m0_wstrb,
      input  m1_req, m1_wr, m1_addr, m1_wdata, m1_wstrb,
      output m0_gnt, m0_rvalid, m0_rdata, m0_stall,
      output m1_gnt, m1_rvalid, m1_rdata,
      output dmem_wr, dmem_waddr, dmem_wdata, dmem_wstrb, dmem_rd, dmem_raddr,
      input  dmem_rdata
   );

   modport master (
`ifdef DBUS_ARB_LOCK_EN
      output m0_lock, m1_lock,
`endif
      output m0_req, m0_wr, m0_addr, m0_wdata, m0_wstrb,
      output m1_req, m1_wr, m1_addr, m1_wdata, m1_wstrb,
      input  m0_gnt, m0_rvalid, m0_rdata, m0_stall,
      input  m1_gnt, m1_rvalid, m1_rdata,
      input  dmem_wr, dmem_waddr, dmem_wdata, dmem_wstrb, dmem_rd, dmem_raddr,
      output dmem_rdata
   );

endinterface

// File: rtl/dbus_arb_rr.sv
// dbus_arb_rr -- combinational grant decision for the two-master arbiter.
// Ports:
//   req0/req1   : request from master 0 (CPU) / master 1 (UART loader)
//   state       : owner of the previous cycle's grant (IDLE if none)
//   count       : consecutive grants the current owner has received
//   last_gnt    : master granted most recently (survives IDLE cycles)
//   lock0/lock1 : owner burst-lock (tied low when the lock build option is off)
//   gnt0/gnt1   : one-hot (or zero) grant for this cycle
module dbus_arb_rr
   import dbus_arb_pkg::*;
#(
   parameter int BURST = BURST_DEFAULT
) (
   input  logic       req0,
   input  logic       req1,
   input  arb_state_t state,
   input  logic [7:0] count,
   input  logic       last_gnt,
   input  logic       lock0,
   input  logic       lock1,
   output logic       gnt0,
   output logic       gnt1
);

   localparam logic [7:0] BURST_CNT = 8'(BURST);

   // Winner under contention only; a sole requester always wins outright.
   // Only the owner's lock is consulted, so a non-owner cannot steal the bus.
   logic win;

   always_comb begin
      win = MST_0;
      case (state)
         ST_OWN0: win = (lock0 || (count < BURST_CNT)) ? MST_0 : MST_1;
         ST_OWN1: win = (lock1 || (count < BURST_CNT)) ? MST_1 : MST_0;
         default: win = ~last_gnt;
      endcase
      gnt0 = req0 & (~req1 | (win == MST_0));
      gnt1 = req1 & (~req0 | (win == MST_1));
   end

endmodule

// File: rtl/dbus_arb.sv
// dbus_arb -- two-master data-bus arbiter in front of a single data memory.
// Master 0 is the CPU (stalled through m0_stall), master 1 the UART loader.
// At most one transfer is forwarded per cycle; grants and slave-port muxing
// are combinational, the read return is registered one cycle after the grant.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : dbus_arb_if.slave -- master request/grant/read-return, m0_stall, dmem_*
// Build option DBUS_ARB_LOCK_EN: owner may hold the bus past BURST via mx_lock.
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | no grant was issued last cycle
// OWN0    | master 0 held last cycle's grant
// OWN1    | master 1 held last cycle's grant
module dbus_arb
   import dbus_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int BURST      = BURST_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   dbus_arb_if.slave  bus
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   arb_state_t            state;
   logic [7:0]            count;
   logic                  last_gnt;
   logic                  rd_vld;
   logic                  rd_owner;

   logic                  rr_gnt0;
   logic                  rr_gnt1;
   logic                  gnt0;
   logic                  gnt1;
   logic                  any_gnt;
   logic                  gnt_idx;
   logic                  lock0;
   logic                  lock1;

   logic                  sel_wr;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic [STRB_WIDTH-1:0] sel_wstrb;

`ifdef DBUS_ARB_LOCK_EN
   assign lock0 = bus.m0_lock;
   assign lock1 = bus.m1_lock;
`else
   assign lock0 = 1'b0;
   assign lock1 = 1'b0;
`endif

   dbus_arb_rr #(.BURST(BURST)) u_rr (
      .req0     (bus.m0_req),
      .req1     (bus.m1_req),
      .state    (state),
      .count    (count),
      .last_gnt (last_gnt),
      .lock0    (lock0),
      .lock1    (lock1),
      .gnt0     (rr_gnt0),
      .gnt1     (rr_gnt1)
   );

   // Grants are combinational, so they are masked directly while rst is high.
   assign gnt0    = rr_gnt0 & ~rst;
   assign gnt1    = rr_gnt1 & ~rst;
   assign any_gnt = gnt0 | gnt1;
   assign gnt_idx = gnt1 ? MST_1 : MST_0;

   always_comb begin
      sel_wr    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_wstrb = '0;
      if (gnt0) begin
         sel_wr    = bus.m0_wr;
         sel_addr  = bus.m0_addr;
         sel_wdata = bus.m0_wdata;
         sel_wstrb = bus.m0_wstrb;
      end else if (gnt1) begin
         sel_wr    = bus.m1_wr;
         sel_addr  = bus.m1_addr;
         sel_wdata = bus.m1_wdata;
         sel_wstrb = bus.m1_wstrb;
      end
   end

   assign bus.dmem_wr    = any_gnt & sel_wr;
   assign bus.dmem_rd    = any_gnt & ~sel_wr;
   assign bus.dmem_waddr = sel_addr;
   assign bus.dmem_raddr = sel_addr;
   assign bus.dmem_wdata = sel_wdata;
   assign bus.dmem_wstrb = sel_wstrb;

   assign bus.m0_gnt   = gnt0;
   assign bus.m1_gnt   = gnt1;
   assign bus.m0_stall = bus.m0_req & ~gnt0;

   assign bus.m0_rvalid = rd_vld & (rd_owner == MST_0);
   assign bus.m1_rvalid = rd_vld & (rd_owner == MST_1);
   assign bus.m0_rdata  = bus.m0_rvalid ? bus.dmem_rdata : '0;
   assign bus.m1_rdata  = bus.m1_rvalid ? bus.dmem_rdata : '0;

   // last_gnt resets to master 1 so the first contention after reset goes to the CPU.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         count    <= 8'd0;
         last_gnt <= MST_1;
         rd_vld   <= 1'b0;
         rd_owner <= MST_0;
      end else begin
         rd_vld <= any_gnt & ~sel_wr;
         if (any_gnt & ~sel_wr) begin
            rd_owner <= gnt_idx;
         end

         if (!any_gnt) begin
            state <= ST_IDLE;
            count <= 8'd0;
         end else if ((state == ST_OWN0 && gnt0) || (state == ST_OWN1 && gnt1)) begin
            count <= cnt_sat_inc(count);
         end else begin
            state <= gnt1 ? ST_OWN1 : ST_OWN0;
            count <= 8'd1;
         end

         if (any_gnt) begin
            last_gnt <= gnt_idx;
         end
      end
   end

endmodule

// File: tb/tb_dbus_arb.sv
// tb_dbus_arb -- directed self-checking bench for dbus_arb.
// Two instances share the stimulus: dut8 (BURST=8) and dut1 (BURST=1); `sel`
// picks which one the checks look at. Read returns go through a scoreboard
// queue: a granted read pushes {master, expected data}, the next cycle pops it.
module tb_dbus_arb;

   typedef struct packed {
      logic        m;
      logic [31:0] data;
   } sb_t;

   logic clk;
   logic rst;
   bit   sel;
   int   total;
   int   bad;
   sb_t  sb[$];

   logic        r0, w0, r1, w1;
   logic [31:0] a0, a1, d0, d1;
   logic [3:0]  s0, s1;
`ifdef DBUS_ARB_LOCK_EN
   logic        l0, l1;
`endif

   dbus_arb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus8 ();
   dbus_arb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

   dbus_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BURST(8)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8)
   );

   dbus_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BURST(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return a ^ 32'hA5A5_5A5A;
   endfunction

   // Data memory: read data valid the cycle after dmem_rd.
   always @(posedge clk) begin
      bus8.dmem_rdata <= bus8.dmem_rd ? mem_f(bus8.dmem_raddr) : 32'h0;
      bus1.dmem_rdata <= bus1.dmem_rd ? mem_f(bus1.dmem_raddr) : 32'h0;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic apply();
      bus8.m0_req = r0; bus8.m0_wr = w0; bus8.m0_addr = a0; bus8.m0_wdata = d0; bus8.m0_wstrb = s0;
      bus8.m1_req = r1; bus8.m1_wr = w1; bus8.m1_addr = a1; bus8.m1_wdata = d1; bus8.m1_wstrb = s1;
      bus1.m0_req = r0; bus1.m0_wr = w0; bus1.m0_addr = a0; bus1.m0_wdata = d0; bus1.m0_wstrb = s0;
      bus1.m1_req = r1; bus1.m1_wr = w1; bus1.m1_addr = a1; bus1.m1_wdata = d1; bus1.m1_wstrb = s1;
`ifdef DBUS_ARB_LOCK_EN
      bus8.m0_lock = l0; bus8.m1_lock = l1;
      bus1.m0_lock = l0; bus1.m1_lock = l1;
`endif
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One bus cycle: inputs are already applied; sample at negedge, then
   // advance to just after the next rising edge.
   task automatic cyc(input logic eg0, input logic eg1);
      logic        g0, g1, st, drd, dwr, rv0, rv1;
      logic [31:0] ra, wa, wd, q0, q1;
      logic [3:0]  ws;
      logic        erd, ewr, erv0, erv1;
      logic [31:0] ea, eq0, eq1;
      sb_t         it;
      @(negedge clk);
      if (sel) begin
         g0 = bus1.m0_gnt; g1 = bus1.m1_gnt; st = bus1.m0_stall;
         drd = bus1.dmem_rd; dwr = bus1.dmem_wr; ra = bus1.dmem_raddr;
         wa = bus1.dmem_waddr; wd = bus1.dmem_wdata; ws = bus1.dmem_wstrb;
         rv0 = bus1.m0_rvalid; rv1 = bus1.m1_rvalid; q0 = bus1.m0_rdata; q1 = bus1.m1_rdata;
      end else begin
         g0 = bus8.m0_gnt; g1 = bus8.m1_gnt; st = bus8.m0_stall;
         drd = bus8.dmem_rd; dwr = bus8.dmem_wr; ra = bus8.dmem_raddr;
         wa = bus8.dmem_waddr; wd = bus8.dmem_wdata; ws = bus8.dmem_wstrb;
         rv0 = bus8.m0_rvalid; rv1 = bus8.m1_rvalid; q0 = bus8.m0_rdata; q1 = bus8.m1_rdata;
      end
      erd = (eg0 & ~w0) | (eg1 & ~w1);
      ewr = (eg0 & w0) | (eg1 & w1);
      ea  = eg0 ? a0 : a1;
      check("m0_gnt", {31'd0, g0}, {31'd0, eg0});
      check("m1_gnt", {31'd0, g1}, {31'd0, eg1});
      check("m0_stall", {31'd0, st}, {31'd0, r0 & ~eg0});
      check("dmem_rd", {31'd0, drd}, {31'd0, erd});
      check("dmem_wr", {31'd0, dwr}, {31'd0, ewr});
      if (erd) check("dmem_raddr", ra, ea);
      if (ewr) begin
         check("dmem_waddr", wa, ea);
         check("dmem_wdata", wd, eg0 ? d0 : d1);
         check("dmem_wstrb", {28'd0, ws}, {28'd0, eg0 ? s0 : s1});
      end
      if (!eg0 && !eg1) check("dmem_idle_zero", ra | wa | wd | {28'd0, ws}, 32'h0);
      erv0 = 1'b0; erv1 = 1'b0; eq0 = 32'h0; eq1 = 32'h0;
      if (sb.size() > 0) begin
         it = sb.pop_front();
         erv0 = ~it.m;
         erv1 = it.m;
         if (!it.m) eq0 = it.data; else eq1 = it.data;
      end
      check("m0_rvalid", {31'd0, rv0}, {31'd0, erv0});
      check("m1_rvalid", {31'd0, rv1}, {31'd0, erv1});
      check("m0_rdata", q0, eq0);
      check("m1_rdata", q1, eq1);
      if (erd) sb.push_back('{m: eg1, data: mem_f(ea)});
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      r0 = 1'b0; w0 = 1'b0; a0 = 32'h0; d0 = 32'h0; s0 = 4'h0;
      r1 = 1'b0; w1 = 1'b0; a1 = 32'h0; d1 = 32'h0; s1 = 4'h0;
`ifdef DBUS_ARB_LOCK_EN
      l0 = 1'b0; l1 = 1'b0;
`endif
   endtask

   task automatic do_reset();
      idle_inputs();
      apply();
      rst = 1'b1;
      sb.delete();
      cyc(1'b0, 1'b0);
      rst = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      sel   = 1'b0;
      rst   = 1'b1;
      idle_inputs();
      apply();

      // Reset state: both masters requesting reads, nothing may be granted.
      r0 = 1'b1; r1 = 1'b1; a0 = 32'h10; a1 = 32'h20;
      apply();
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      rst = 1'b0;

      // Single CPU read: same-cycle grant, data returned next cycle.
      idle_inputs();
      r0 = 1'b1; a0 = 32'h0100_0010;
      apply();
      cyc(1'b1, 1'b0);
      idle_inputs(); apply();
      cyc(1'b0, 1'b0);

      // Loader write with CPU idle; no read return may follow.
      r1 = 1'b1; w1 = 1'b1; a1 = 32'h0000_0040; d1 = 32'hDEAD_BEEF; s1 = 4'hF;
      apply();
      cyc(1'b0, 1'b1);
      idle_inputs(); apply();
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);

      // BURST=8 continuous contention from IDLE after reset.
      do_reset();
      for (int i = 0; i < 32; i++) begin
         r0 = 1'b1; a0 = 32'h0000_1000 + 32'(i * 4);
         r1 = 1'b1; a1 = 32'h0000_2000 + 32'(i * 4);
         apply();
         cyc(((i / 8) % 2) == 0, ((i / 8) % 2) == 1);
      end
      idle_inputs(); apply();
      cyc(1'b0, 1'b0);

      // BURST=1 alternating reads with per-master return routing.
      sel = 1'b1;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         r0 = 1'b1; a0 = 32'h0200_0000;
         r1 = 1'b1; a1 = 32'h0300_0004;
         apply();
         cyc((i % 2) == 0, (i % 2) == 1);
      end
      idle_inputs(); apply();
      cyc(1'b0, 1'b0);
      sel = 1'b0;
      cyc(1'b0, 1'b0);

      // Reset right after a granted read: the return is dropped, and the
      // first contention after release goes to the CPU.
      do_reset();
      r1 = 1'b1; w1 = 1'b1; a1 = 32'h80; d1 = 32'h1234_5678; s1 = 4'h3;
      apply();
      cyc(1'b0, 1'b1);
      idle_inputs();
      r0 = 1'b1; a0 = 32'h0400_0008;
      apply();
      cyc(1'b1, 1'b0);
      rst = 1'b1;
      sb.delete();
      r0 = 1'b1; r1 = 1'b1; a0 = 32'h0400_000C; a1 = 32'h0500_0000;
      apply();
      cyc(1'b0, 1'b0);
      rst = 1'b0;
      cyc(1'b1, 1'b0);
      idle_inputs(); apply();
      cyc(1'b0, 1'b0);

`ifdef DBUS_ARB_LOCK_EN
      // Loader owns the bus with lock held past BURST; CPU lock is ignored.
      do_reset();
      r1 = 1'b1; w1 = 1'b1; a1 = 32'h100; d1 = 32'hCAFE_0001; s1 = 4'hF; l1 = 1'b1;
      apply();
      cyc(1'b0, 1'b1);
      r0 = 1'b1; w0 = 1'b1; a0 = 32'h200; d0 = 32'hBEEF_0002; s0 = 4'h1; l0 = 1'b1;
      for (int i = 0; i < 12; i++) begin
         apply();
         cyc(1'b0, 1'b1);
      end
      l1 = 1'b0;
      apply();
      cyc(1'b1, 1'b0);
      idle_inputs(); apply();
      cyc(1'b0, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
